// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data requesters.
// One outstanding transaction; data wins unless fetch has been starved STARVE_LIMIT times.
module sram_req_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t     state;
  req_t       lat;
  logic [3:0] streak;
  logic       force_inst, grant_data, grant_inst;
  logic       addr_hit, data_hit;

  // Fetch is forced only once data has won STARVE_LIMIT times in a row against it.
  always_comb begin
    force_inst = (STARVE_LIMIT != 0) && (streak == 4'(STARVE_LIMIT));
    grant_data = data_req && !(inst_req && force_inst);
    grant_inst = inst_req && !grant_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      owner  <= 1'b0;
      lat    <= '0;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state  <= ADDR;
            owner  <= 1'b1;
            lat    <= '{wen: data_wen, addr: data_addr, wdata: data_wdata};
            streak <= !inst_req ? 4'd0 : (streak == 4'hF) ? streak : streak + 4'd1;
          end else if (grant_inst) begin
            state  <= ADDR;
            owner  <= 1'b0;
            lat    <= '{wen: 4'h0, addr: inst_addr, wdata: 32'h0};
            streak <= 4'd0;
          end
        end
        ADDR:    if (mem_addr_ok) state <= DATA;
        DATA:    if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes are combinational pass-throughs, qualified by state so stray
  // memory pulses outside the matching phase are dropped.
  assign addr_hit     = (state == ADDR) && mem_addr_ok;
  assign data_hit     = (state == DATA) && mem_data_ok;

  assign mem_req      = (state == ADDR);
  assign mem_wen      = lat.wen;
  assign mem_addr     = lat.addr;
  assign mem_wdata    = lat.wdata;
  assign busy         = (state != IDLE);

  assign inst_addr_ok = addr_hit && !owner;
  assign data_addr_ok = addr_hit &&  owner;
  assign inst_data_ok = data_hit && !owner;
  assign data_data_ok = data_hit &&  owner;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: reset, write, read routing, reset abort,
// and grant ordering with the starvation guard enabled and disabled.
module tb_sram_req_arbiter;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
  logic [3:0]  data_wen = '0;
  logic        man_addr_ok = 1'b0, man_data_ok = 1'b0, auto_mem = 1'b0;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        mem_req, mem_addr_ok, mem_data_ok, busy, owner;

  logic        z_inst_addr_ok, z_inst_data_ok, z_data_addr_ok, z_data_data_ok;
  logic [31:0] z_inst_rdata, z_data_rdata, z_mem_addr, z_mem_wdata;
  logic [3:0]  z_mem_wen;
  logic        z_mem_req, z_busy, z_owner;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // Auto memory accepts immediately and completes the next cycle.
  assign mem_addr_ok = auto_mem ? mem_req : man_addr_ok;
  assign mem_data_ok = auto_mem ? (busy && !mem_req) : man_data_ok;

  sram_req_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  sram_req_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(z_inst_addr_ok), .inst_data_ok(z_inst_data_ok), .inst_rdata(z_inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(z_data_addr_ok), .data_data_ok(z_data_data_ok), .data_rdata(z_data_rdata),
    .mem_req(z_mem_req), .mem_wen(z_mem_wen), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_addr_ok(z_mem_req), .mem_data_ok(z_busy && !z_mem_req), .mem_rdata(mem_rdata),
    .busy(z_busy), .owner(z_owner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_g, n_z;
    logic [9:0] g, gz;

    // Reset held with a fetch pending: every output quiet.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    chk("rst_rdata", inst_rdata | data_rdata, 0);
    resetn = 1'b1;
    tick;
    chk("boot_mem_req", mem_req, 1);
    chk("boot_owner", owner, 0);
    chk("boot_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("boot_mem_wen", mem_wen, 0);
    man_addr_ok = 1'b1; #1;
    chk("boot_inst_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1;
    tick;
    man_data_ok = 1'b0;

    // Single data write, memory accepts on the third ADDR cycle.
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
    tick;
    data_wdata = 32'h0;  // post-grant change must not reach memory
    chk("wr_mem_req", mem_req, 1);
    chk("wr_owner", owner, 1);
    chk("wr_mem_wen", mem_wen, 4'hF);
    chk("wr_mem_addr", mem_addr, 32'h0000_1000);
    chk("wr_addr_ok_early", data_addr_ok, 0);
    tick;
    chk("wr_addr_ok_wait", data_addr_ok, 0);
    tick;
    man_addr_ok = 1'b1; #1;
    chk("wr_data_addr_ok", data_addr_ok, 1);
    chk("wr_mem_wdata_held", mem_wdata, 32'hDEAD_BEEF);
    tick;
    data_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1; #1;
    chk("wr_mem_req_data", mem_req, 0);
    chk("wr_addr_ok_pulse", data_addr_ok, 0);
    chk("wr_data_data_ok", data_data_ok, 1);
    chk("wr_inst_quiet", {inst_addr_ok, inst_data_ok, 1'b0} | inst_rdata, 0);
    tick;
    man_data_ok = 1'b0; #1;
    chk("wr_data_ok_pulse", data_data_ok, 0);
    chk("wr_idle", busy, 0);

    // Inst read routing; a stray data_ok during ADDR is ignored.
    inst_req = 1'b1; inst_addr = 32'h0000_0040; data_wen = 4'h0;
    tick;
    man_data_ok = 1'b1; mem_rdata = 32'h1111_1111; #1;
    chk("rd_stray_data_ok", inst_data_ok, 0);
    chk("rd_stray_busy", busy, 1);
    man_data_ok = 1'b0; man_addr_ok = 1'b1; #1;
    chk("rd_inst_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1; mem_rdata = 32'h2402_0001; #1;
    chk("rd_inst_data_ok", inst_data_ok, 1);
    chk("rd_inst_rdata", inst_rdata, 32'h2402_0001);
    chk("rd_data_rdata", data_rdata, 0);
    chk("rd_data_data_ok", data_data_ok, 0);
    tick;
    man_data_ok = 1'b0;

    // Reset while waiting for read data: late mem_data_ok must be dropped.
    data_req = 1'b1; data_addr = 32'h0000_2000;
    tick;
    man_addr_ok = 1'b1;
    tick;
    data_req = 1'b0; man_addr_ok = 1'b0;
    chk("abort_in_data", busy && !mem_req, 1);
    resetn = 1'b0; #1;
    chk("abort_busy_now", busy, 0);
    tick;
    resetn = 1'b1; man_data_ok = 1'b1; #1;
    chk("abort_oks", {inst_data_ok, data_data_ok}, 0);
    chk("abort_busy", busy, 0);
    tick;
    man_data_ok = 1'b0;
    chk("abort_still_idle", busy, 0);

    // Contention with both requests held high.
    resetn = 1'b0; auto_mem = 1'b1;
    tick;
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h100; data_addr = 32'h200;
    resetn = 1'b1;
    n_g = 0; n_z = 0; g = '0; gz = '0;
    for (int c = 0; c < 60 && (n_g < 10 || n_z < 10); c++) begin
      tick;
      if (mem_req && n_g < 10) begin
        g[n_g] = owner;
        if (!owner) chk($sformatf("streak_clear_%0d", n_g), dut.streak, 0);
        n_g++;
      end
      if (z_mem_req && n_z < 10) begin
        gz[n_z] = z_owner;
        n_z++;
      end
    end
    chk("cont_grant_count", n_g, 10);
    chk("cont0_grant_count", n_z, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("cont_grant_%0d", i), g[i], (i % 5 == 4) ? 0 : 1);
      chk($sformatf("cont0_grant_%0d", i), gz[i], 1);
    end
    inst_req = 1'b0; data_req = 1'b0;
    tick; tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the core's instruction-fetch requester and data requester.
- Sits between mycpu_core, after the per-side mmu translation, and the unified memory interface.
- Allows one outstanding transaction at a time.
- Data has priority over instruction, with a bounded-starvation guard so fetch always makes progress.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced; 0 = guard disabled (pure data priority); legal 0..15.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  instruction read request; held with inst_addr until inst_addr_ok
- inst_addr  in  32  physical fetch address
- inst_addr_ok  out  1  one-cycle pulse: inst request accepted by memory
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  fetched word
- data_req  in  1  data request; held with data_wen/addr/wdata until data_addr_ok
- data_wen  in  4  byte write enables; 0 = read
- data_addr  in  32  physical data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  one-cycle pulse: data request accepted
- data_data_ok  out  1  one-cycle pulse: read data valid / write complete
- data_rdata  out  32  load word
- mem_req  out  1  request to memory
- mem_wen  out  4  byte enables to memory
- mem_addr  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_addr_ok  in  1  memory accepted address this cycle (qualified by mem_req)
- mem_data_ok  in  1  memory completed transaction this cycle
- mem_rdata  in  32  memory read data, valid with mem_data_ok
- busy  out  1  high whenever state != IDLE
- owner  out  1  current owner: 0 = inst, 1 = data; meaningful only while busy

Behaviour:
- States: IDLE, ADDR, DATA.
- Registers: state, owner, latched wen/addr/wdata, streak counter (4 bits).
- Reset (resetn low, async):
  - state = IDLE, owner = 0, latches = 0, streak = 0.
  - All outputs are 0, including mem_req, addr_ok/data_ok, rdata, busy.
  - A transaction interrupted by reset is abandoned.
  - mem_data_ok arriving after reset is ignored.
- IDLE, grant decision on the clock edge:
  - Only data_req: grant data.
  - Only inst_req: grant inst.
  - Both pending: grant inst if STARVE_LIMIT != 0 and streak == STARVE_LIMIT; otherwise grant data.
  - On any grant: latch owner and payload, go to ADDR. Inst grants latch mem_wen = 0 and mem_wdata = 0.
  - No request: remain in IDLE.
- Streak counter:
  - On a data grant while inst_req = 1: streak = streak + 1, saturating at 15.
  - On an inst grant: streak = 0.
  - On a data grant with inst_req = 0: streak = 0.
- ADDR state:
  - mem_req = 1; mem_wen/addr/wdata are driven from the latches.
  - When mem_addr_ok = 1: the owner's addr_ok is asserted combinationally in the same cycle, then go to DATA.
  - Otherwise hold, with payload stable.
- DATA state:
  - mem_req = 0.
  - When mem_data_ok = 1: the owner's data_ok is asserted combinationally in the same cycle, and the owner's rdata = mem_rdata (combinational pass-through). Then go to IDLE.
  - The non-owner's addr_ok/data_ok stay 0. The non-owner's rdata is 0.
- mem_addr_ok or mem_data_ok outside ADDR or DATA respectively is ignored.
- Minimum occupancy: 3 cycles per transaction (grant, addr_ok, data_ok). Back-to-back requests therefore issue at most every 3 cycles.
- Requester obligation:
  - Hold req and payload until addr_ok.
  - The arbiter samples the payload only at grant; changes after grant are ignored.
  - A request deasserted before grant is never issued.
- busy = (state != IDLE); owner holds its last value while in IDLE.

Test Plan:
- Reset: hold resetn = 0 with inst_req = 1 -> all outputs 0. Release resetn; at the first edge owner = 0, state ADDR, mem_addr = inst_addr = 0xBFC00000 (as issued by the core), mem_wen = 0.
- Single data write: data_req = 1, wen = 4'hF, addr 0x00001000, wdata 0xDEADBEEF; memory returns addr_ok 2 cycles after mem_req, then data_ok 1 cycle later. Required: data_addr_ok and data_data_ok pulse exactly one cycle each; inst_* outputs stay 0.
- Contention, STARVE_LIMIT = 4: data_req and inst_req held high continuously -> grant order D, D, D, D, I, D, D, D, D, I; streak returns to 0 after each I.
- STARVE_LIMIT = 0, same stimulus -> inst is never granted while data_req remains high.
- Read routing: inst read of addr 0x00000040, mem_rdata = 0x24020001 -> inst_data_ok = 1 with inst_rdata = 0x24020001 in the same cycle; data_rdata = 0.
- Reset mid-op: in DATA, assert resetn = 0 for 1 cycle, then pulse mem_data_ok -> no data_ok to either requester; state IDLE, busy = 0.
